// File: rtl/mips_pkg.sv
// Shared MIPS encodings and helpers for the pipeline control slice.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Values the D/E register loads when this block inserts a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] NOP_PC4   = 32'h0000_3004;
  localparam logic [31:0] NOP_PC8   = 32'h0000_3008;

  localparam logic [1:0] T_NONE = 2'd3;

  typedef enum logic [4:0] {
    I_NOP, I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR,
    I_MULT, I_MULTU, I_DIV, I_DIVU, I_MFHI, I_MFLO, I_MTHI, I_MTLO
  } instr_e;

  function automatic instr_e classify(input logic [31:0] ir);
    instr_e cls;
    cls = I_NOP;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          FN_ADDU:  cls = I_ADDU;
          FN_SUBU:  cls = I_SUBU;
          FN_JR:    cls = I_JR;
          FN_MULT:  cls = I_MULT;
          FN_MULTU: cls = I_MULTU;
          FN_DIV:   cls = I_DIV;
          FN_DIVU:  cls = I_DIVU;
          FN_MFHI:  cls = I_MFHI;
          FN_MFLO:  cls = I_MFLO;
          FN_MTHI:  cls = I_MTHI;
          FN_MTLO:  cls = I_MTLO;
          default:  cls = I_NOP;
        endcase
      end
      OP_ORI:  cls = I_ORI;
      OP_LUI:  cls = I_LUI;
      OP_LW:   cls = I_LW;
      OP_SW:   cls = I_SW;
      OP_BEQ:  cls = I_BEQ;
      OP_J:    cls = I_J;
      OP_JAL:  cls = I_JAL;
      default: cls = I_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Per-stage instruction classifier: register fields, destination, Tuse/Tnew and mult/div flags.
module instr_class_dec
  import mips_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_dst,
  output logic [1:0]  o_tuse_rs,
  output logic [1:0]  o_tuse_rt,
  output logic [1:0]  o_tnew_e,
  output logic        o_is_md_start,
  output logic        o_is_md_any
);

  instr_e     w_cls;
  logic [4:0] w_rd;
  logic       w_unused_shamt;

  assign w_cls          = classify(i_ir);
  assign o_rs           = i_ir[25:21];
  assign o_rt           = i_ir[20:16];
  assign w_rd           = i_ir[15:11];
  assign w_unused_shamt = ^i_ir[10:6];

  // A destination of $0 doubles as "no destination"; it can never stall.
  always_comb begin
    o_dst         = REG_ZERO;
    o_tuse_rs     = T_NONE;
    o_tuse_rt     = T_NONE;
    o_tnew_e      = 2'd0;
    o_is_md_start = 1'b0;
    o_is_md_any   = 1'b0;
    case (w_cls)
      I_ADDU, I_SUBU: begin
        o_dst = w_rd; o_tuse_rs = 2'd1; o_tuse_rt = 2'd1; o_tnew_e = 2'd1;
      end
      I_ORI: begin
        o_dst = o_rt; o_tuse_rs = 2'd1; o_tnew_e = 2'd1;
      end
      I_LUI: begin
        o_dst = o_rt; o_tnew_e = 2'd1;
      end
      I_LW: begin
        o_dst = o_rt; o_tuse_rs = 2'd1; o_tnew_e = 2'd2;
      end
      I_SW: begin
        o_tuse_rs = 2'd1; o_tuse_rt = 2'd2;
      end
      I_BEQ: begin
        o_tuse_rs = 2'd0; o_tuse_rt = 2'd0;
      end
      I_JAL: o_dst = REG_RA;
      I_JR:  o_tuse_rs = 2'd0;
      I_MULT, I_MULTU, I_DIV, I_DIVU: begin
        o_tuse_rs = 2'd1; o_tuse_rt = 2'd1; o_is_md_start = 1'b1; o_is_md_any = 1'b1;
      end
      I_MFHI, I_MFLO: begin
        o_dst = w_rd; o_tnew_e = 2'd1; o_is_md_any = 1'b1;
      end
      I_MTHI, I_MTLO: begin
        o_tuse_rs = 2'd1; o_is_md_any = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew RAW checks plus mult/div busy tracking.
// Optional HAZARD_STALL_CNT_EN adds a free-running stall cycle counter output.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_e,
  input  logic [31:0] ir_m,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_flush,
  output logic        md_busy,
  output logic        stall
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [4:0] w_d_rs, w_d_rt, w_d_dst, w_e_rs, w_e_rt, w_e_dst, w_m_rs, w_m_rt, w_m_dst;
  logic [1:0] w_d_tuse_rs, w_d_tuse_rt, w_d_tnew;
  logic [1:0] w_e_tuse_rs, w_e_tuse_rt, w_e_tnew;
  logic [1:0] w_m_tuse_rs, w_m_tuse_rt, w_m_tnew, w_m_tnew_m;
  logic       w_d_md_start, w_d_md_any, w_e_md_start, w_e_md_any, w_m_md_start, w_m_md_any;
  logic       w_raw_rs, w_raw_rt, w_md_stall, w_stall, w_e_is_div, w_unused_dec;
  logic [CNT_W-1:0] r_busy_cnt;

  instr_class_dec u_dec_d (
    .i_ir(ir_d), .o_rs(w_d_rs), .o_rt(w_d_rt), .o_dst(w_d_dst),
    .o_tuse_rs(w_d_tuse_rs), .o_tuse_rt(w_d_tuse_rt), .o_tnew_e(w_d_tnew),
    .o_is_md_start(w_d_md_start), .o_is_md_any(w_d_md_any)
  );

  instr_class_dec u_dec_e (
    .i_ir(ir_e), .o_rs(w_e_rs), .o_rt(w_e_rt), .o_dst(w_e_dst),
    .o_tuse_rs(w_e_tuse_rs), .o_tuse_rt(w_e_tuse_rt), .o_tnew_e(w_e_tnew),
    .o_is_md_start(w_e_md_start), .o_is_md_any(w_e_md_any)
  );

  instr_class_dec u_dec_m (
    .i_ir(ir_m), .o_rs(w_m_rs), .o_rt(w_m_rt), .o_dst(w_m_dst),
    .o_tuse_rs(w_m_tuse_rs), .o_tuse_rt(w_m_tuse_rt), .o_tnew_e(w_m_tnew),
    .o_is_md_start(w_m_md_start), .o_is_md_any(w_m_md_any)
  );

  assign w_unused_dec = ^{w_d_dst, w_d_tnew, w_d_md_start, w_e_rs, w_e_rt, w_e_tuse_rs,
                          w_e_tuse_rt, w_e_md_any, w_m_rs, w_m_rt, w_m_tuse_rs,
                          w_m_tuse_rt, w_m_md_start, w_m_md_any};

  // One stage later the producer is a cycle closer to its result.
  assign w_m_tnew_m = (w_m_tnew == 2'd0) ? 2'd0 : w_m_tnew - 2'd1;

  assign w_raw_rs = (w_d_rs != REG_ZERO) &&
                    (((w_d_rs == w_e_dst) && (w_d_tuse_rs < w_e_tnew)) ||
                     ((w_d_rs == w_m_dst) && (w_d_tuse_rs < w_m_tnew_m)));
  assign w_raw_rt = (w_d_rt != REG_ZERO) &&
                    (((w_d_rt == w_e_dst) && (w_d_tuse_rt < w_e_tnew)) ||
                     ((w_d_rt == w_m_dst) && (w_d_tuse_rt < w_m_tnew_m)));

  assign w_md_stall = w_d_md_any && (md_busy || w_e_md_start);
  assign w_stall    = w_raw_rs || w_raw_rt || w_md_stall;
  assign w_e_is_div = classify(ir_e) inside {I_DIV, I_DIVU};

  assign stall    = w_stall;
  assign pc_en    = ~w_stall;
  assign fd_en    = ~w_stall;
  assign de_flush = w_stall;
  assign md_busy  = (r_busy_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_cnt <= '0;
    end else if (w_e_md_start) begin
      r_busy_cnt <= w_e_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_busy_cnt != '0) begin
      r_busy_cnt <= r_busy_cnt - 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed hazard scenarios plus random pipeline traffic.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir_d = '0;
  logic [31:0] ir_e = '0;
  logic [31:0] ir_m = '0;
  logic        pc_en, fd_en, de_flush, md_busy, stall;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  int          m_busy = 0;
  int unsigned m_scnt = 0;

  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_JR = 6'h08;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] O_ORI = 6'h0d, O_LUI = 6'h0f, O_LW = 6'h23, O_SW = 6'h2b;
  localparam logic [5:0] O_BEQ = 6'h04, O_J = 6'h02, O_JAL = 6'h03;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .ir_d(ir_d), .ir_e(ir_e), .ir_m(ir_m),
    .pc_en(pc_en), .fd_en(fd_en), .de_flush(de_flush), .md_busy(md_busy), .stall(stall)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef enum {NOP, ADDU, SUBU, ORI, LUI, LW, SW, BEQ, JMP, JAL, JR,
                MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO} mn_t;

  function automatic mn_t mn(input logic [31:0] ir);
    logic [5:0] fn;
    fn = ir[5:0];
    case (ir[31:26])
      6'h00: begin
        if (fn == F_ADDU) return ADDU;
        if (fn == F_SUBU) return SUBU;
        if (fn == F_JR) return JR;
        if (fn == F_MULT) return MULT;
        if (fn == F_MULTU) return MULTU;
        if (fn == F_DIV) return DIV;
        if (fn == F_DIVU) return DIVU;
        if (fn == F_MFHI) return MFHI;
        if (fn == F_MFLO) return MFLO;
        if (fn == F_MTHI) return MTHI;
        if (fn == F_MTLO) return MTLO;
        return NOP;
      end
      O_ORI: return ORI;
      O_LUI: return LUI;
      O_LW:  return LW;
      O_SW:  return SW;
      O_BEQ: return BEQ;
      O_J:   return JMP;
      O_JAL: return JAL;
      default: return NOP;
    endcase
  endfunction

  function automatic int dst_of(input logic [31:0] ir);
    case (mn(ir))
      ADDU, SUBU, MFHI, MFLO: return int'(ir[15:11]);
      ORI, LUI, LW:           return int'(ir[20:16]);
      JAL:                    return 31;
      default:                return 0;
    endcase
  endfunction

  function automatic int tuse_rs(input logic [31:0] ir);
    case (mn(ir))
      BEQ, JR: return 0;
      ADDU, SUBU, ORI, LW, SW, MULT, MULTU, DIV, DIVU, MTHI, MTLO: return 1;
      default: return 99;
    endcase
  endfunction

  function automatic int tuse_rt(input logic [31:0] ir);
    case (mn(ir))
      BEQ: return 0;
      ADDU, SUBU, MULT, MULTU, DIV, DIVU: return 1;
      SW: return 2;
      default: return 99;
    endcase
  endfunction

  function automatic int tnew_in_e(input logic [31:0] ir);
    case (mn(ir))
      LW: return 2;
      ADDU, SUBU, ORI, LUI, MFHI, MFLO: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int tnew_in_m(input logic [31:0] ir);
    return (mn(ir) == LW) ? 1 : 0;
  endfunction

  function automatic bit raw_on(input int r, input int tuse, input logic [31:0] e, input logic [31:0] m);
    if (r == 0) return 1'b0;
    return ((dst_of(e) == r) && (tuse < tnew_in_e(e))) || ((dst_of(m) == r) && (tuse < tnew_in_m(m)));
  endfunction

  function automatic bit ref_stall(input logic [31:0] d, input logic [31:0] e,
                                   input logic [31:0] m, input int busy);
    bit raw, md;
    raw = raw_on(int'(d[25:21]), tuse_rs(d), e, m) || raw_on(int'(d[20:16]), tuse_rt(d), e, m);
    md  = (mn(d) inside {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}) &&
          ((busy > 0) || (mn(e) inside {MULT, MULTU, DIV, DIVU}));
    return raw || md;
  endfunction

  function automatic logic [4:0] exp_vec();
    logic s;
    s = ref_stall(ir_d, ir_e, ir_m, m_busy);
    return {~s, ~s, s, s, (m_busy > 0)};
  endfunction

  function automatic logic [4:0] obs();
    return {pc_en, fd_en, de_flush, stall, md_busy};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0;
      m_scnt <= 0;
    end else begin
      if (ref_stall(ir_d, ir_e, ir_m, m_busy)) m_scnt <= m_scnt + 1;
      case (mn(ir_e))
        MULT, MULTU: m_busy <= 5;
        DIV, DIVU:   m_busy <= 10;
        default:     if (m_busy > 0) m_busy <= m_busy - 1;
      endcase
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h0004};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k = $urandom_range(0, 19);
    int a = $urandom_range(0, 3);
    int b = $urandom_range(0, 3);
    int c = $urandom_range(0, 3);
    case (k)
      0:  return enc_r(F_ADDU, a, b, c);
      1:  return enc_r(F_SUBU, a, b, c);
      2:  return enc_i(O_ORI, a, b);
      3:  return enc_i(O_LUI, 0, b);
      4:  return enc_i(O_LW, a, b);
      5:  return enc_i(O_SW, a, b);
      6:  return enc_i(O_BEQ, a, b);
      7:  return {O_J, 26'h40};
      8:  return {O_JAL, 26'h100};
      9:  return enc_r(F_JR, (a == 0) ? 31 : a, 0, 0);
      10: return enc_r(F_MULT, a, b, 0);
      11: return enc_r(F_MULTU, a, b, 0);
      12: return enc_r(F_DIV, a, b, 0);
      13: return enc_r(F_DIVU, a, b, 0);
      14: return enc_r(F_MFHI, 0, 0, c);
      15: return enc_r(F_MFLO, 0, 0, c);
      16: return enc_r(F_MTHI, a, 0, 0);
      17: return enc_r(F_MTLO, a, 0, 0);
      18: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    @(negedge clk);
    ir_d = d; ir_e = e; ir_m = m;
    #1;
  endtask

  // Moves the pipeline one cycle, holding D and bubbling E whenever the model says stall.
  task automatic advance(input logic [31:0] nxt);
    logic s;
    s = ref_stall(ir_d, ir_e, ir_m, m_busy);
    @(negedge clk);
    ir_m = ir_e;
    if (s) ir_e = '0;
    else begin
      ir_e = ir_d;
      ir_d = nxt;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0, '0, '0);
    drive('0, '0, '0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive('0, '0, '0);
    drive('0, '0, '0);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 5'b11000);
    end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_lw_use();
    drive(enc_r(F_ADDU, 1, 3, 2), enc_i(O_LW, 0, 1), '0);
    checks++;
    if (obs() !== 5'b00110) begin
      failures++; $display("FAIL lw_use_e got=%b exp=%b", obs(), 5'b00110);
    end
    advance('0);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL lw_use_m got=%b exp=%b", obs(), 5'b11000);
    end
  endtask

  task automatic test_branch();
    drive(enc_i(O_BEQ, 4, 5), enc_r(F_ADDU, 1, 2, 4), '0);
    checks++;
    if (obs() !== 5'b00110) begin
      failures++; $display("FAIL beq_addu_e got=%b exp=%b", obs(), 5'b00110);
    end
    advance('0);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL beq_addu_m got=%b exp=%b", obs(), 5'b11000);
    end
    drive(enc_r(F_JR, 31, 0, 0), {O_JAL, 26'h100}, '0);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL jr_jal_e got=%b exp=%b", obs(), 5'b11000);
    end
    drive(enc_i(O_BEQ, 4, 5), '0, enc_i(O_LW, 0, 4));
    checks++;
    if (obs() !== 5'b00110) begin
      failures++; $display("FAIL beq_lw_m got=%b exp=%b", obs(), 5'b00110);
    end
  endtask

  task automatic test_sw();
    drive(enc_i(O_SW, 2, 1), enc_i(O_LW, 0, 1), '0);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL sw_rt_lw_e got=%b exp=%b", obs(), 5'b11000);
    end
    drive(enc_i(O_SW, 2, 1), enc_i(O_LW, 0, 2), '0);
    checks++;
    if (obs() !== 5'b00110) begin
      failures++; $display("FAIL sw_rs_lw_e got=%b exp=%b", obs(), 5'b00110);
    end
    drive(enc_i(O_SW, 2, 1), '0, enc_i(O_LW, 0, 1));
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL sw_rt_lw_m got=%b exp=%b", obs(), 5'b11000);
    end
  endtask

  task automatic test_zero();
    drive(enc_r(F_ADDU, 0, 0, 3), enc_r(F_ADDU, 1, 2, 0), enc_i(O_LW, 0, 0));
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL zero_reg got=%b exp=%b", obs(), 5'b11000);
    end
  endtask

  task automatic test_md(input string name, input logic [31:0] e_instr, input int exp_s, input int exp_b);
    int ns = 0;
    int nb = 0;
    do_reset();
    drive(enc_r(F_MFLO, 0, 0, 2), e_instr, '0);
    for (int i = 0; i < 40 && stall === 1'b1; i++) begin
      ns++;
      if (md_busy === 1'b1) nb++;
      advance('0);
    end
    checks++;
    if (ns != exp_s) begin
      failures++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, ns, exp_s);
    end
    checks++;
    if (nb != exp_b) begin
      failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, nb, exp_b);
    end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'(exp_s)) begin
      failures++; $display("FAIL %s_stall_cnt got=%0d exp=%0d", name, stall_cnt, exp_s);
    end
`endif
  endtask

  task automatic test_load_wins();
    int nb = 0;
    drive('0, enc_r(F_DIV, 1, 2, 0), '0);
    drive('0, enc_r(F_MULT, 1, 2, 0), '0);
    drive('0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      if (md_busy === 1'b1) nb++;
      drive('0, '0, '0);
    end
    checks++;
    if (nb != 5) begin
      failures++; $display("FAIL load_wins_busy got=%0d exp=5", nb);
    end
  endtask

  task automatic test_reset_midcount();
    drive('0, enc_r(F_DIVU, 1, 2, 0), '0);
    repeat (4) drive('0, '0, '0);
    checks++;
    if (md_busy !== 1'b1) begin
      failures++; $display("FAIL midcount_busy got=%b exp=1", md_busy);
    end
    reset = 1'b1;
    drive('0, '0, '0);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++; $display("FAIL midcount_reset got=%b exp=%b", obs(), 5'b11000);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      advance(rand_instr());
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL random_cyc%0d got=%b exp=%b d=%h e=%h m=%h", i, obs(), exp_vec(), ir_d, ir_e, ir_m);
      end
`ifdef HAZARD_STALL_CNT_EN
      checks++;
      if (stall_cnt !== m_scnt) begin
        failures++; $display("FAIL random_stall_cnt%0d got=%0d exp=%0d", i, stall_cnt, m_scnt);
      end
`endif
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw_use();
    test_branch();
    test_sw();
    test_zero();
    test_md("mult", enc_r(F_MULT, 1, 2, 0), 6, 5);
    test_md("div", enc_r(F_DIV, 1, 2, 0), 11, 10);
    test_load_wins();
    test_reset_midcount();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
